// File: rtl/linea_scroll_ctrl.sv
// rtl/linea_scroll_ctrl.sv - lane-marker scroll controller: frame-locked posy update, speed FSM.
// Optional lap counter output o_laps enabled by defining LINEA_SCROLL_LAPS_EN.
module linea_scroll_ctrl #(
    parameter logic [9:0] LANE_X     = 10'd305,
    parameter logic [9:0] INIT_Y     = 10'd0,
    parameter logic [9:0] WRAP_Y     = 10'd480,
    parameter logic [9:0] FRAME_LINE = 10'd480,
    parameter int         FRAC       = 2,
    parameter int         SPEED_W    = 4,
    parameter logic [SPEED_W-1:0] MAX_SPEED = 4'd12
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [9:0]         i_hcount,
    input  logic [9:0]         i_vcount,
    input  logic               i_run,
    input  logic               i_speed_up,
    input  logic               i_speed_down,
    output logic [9:0]         o_posx,
    output logic [9:0]         o_posy,
    output logic [SPEED_W-1:0] o_speed,
    output logic               o_moving,
    output logic               o_frame_tick
`ifdef LINEA_SCROLL_LAPS_EN
    ,
    output logic [15:0]        o_laps
`endif
);
    localparam int PW = 10 + FRAC;
    localparam logic [SPEED_W-1:0] SP_ONE = 1;
    localparam logic [SPEED_W-1:0] SP_ZERO = '0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t             r_state, w_state_nxt;
    logic [SPEED_W-1:0] r_speed, w_speed_nxt;
    logic [PW-1:0]      r_pos, w_pos_sum, w_pos_nxt;
    logic               r_match, r_match_d, w_apply, w_wrap;
    logic               r_up_req, r_dn_req;

    assign w_apply   = r_match & ~r_match_d;
    assign w_pos_sum = r_pos + {{(PW-SPEED_W){1'b0}}, r_speed};
    assign w_wrap    = (w_pos_sum[PW-1:FRAC] >= WRAP_Y);
    // Wrap subtracts whole lines only, so the fractional phase carries across.
    assign w_pos_nxt = w_wrap ? (w_pos_sum - {WRAP_Y, {FRAC{1'b0}}}) : w_pos_sum;

    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        case (r_state)
            S_IDLE: begin
                w_speed_nxt = SP_ZERO;
                if (i_run) begin
                    w_state_nxt = S_RUN;
                    w_speed_nxt = SP_ONE;
                end
            end
            S_RUN: begin
                if (!i_run) begin
                    w_state_nxt = S_STOP;
                    w_speed_nxt = r_speed - SP_ONE;
                end else if (r_up_req && !r_dn_req && r_speed < MAX_SPEED) begin
                    w_speed_nxt = r_speed + SP_ONE;
                end else if (r_dn_req && !r_up_req && r_speed > SP_ONE) begin
                    w_speed_nxt = r_speed - SP_ONE;
                end
            end
            S_STOP: begin
                if (i_run) begin
                    w_state_nxt = S_RUN;
                    w_speed_nxt = (r_speed == SP_ZERO) ? SP_ONE : r_speed;
                end else if (r_speed <= SP_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_speed_nxt = SP_ZERO;
                end else begin
                    w_speed_nxt = r_speed - SP_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_speed_nxt = SP_ZERO;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_speed   <= SP_ZERO;
            r_pos     <= {INIT_Y, {FRAC{1'b0}}};
            r_match   <= 1'b0;
            r_match_d <= 1'b0;
            r_up_req  <= 1'b0;
            r_dn_req  <= 1'b0;
        end else begin
            r_match   <= (i_vcount == FRAME_LINE) && (i_hcount == 10'd0);
            r_match_d <= r_match;
            if (w_apply) begin
                r_state  <= w_state_nxt;
                r_speed  <= w_speed_nxt;
                r_pos    <= w_pos_nxt;
                // A press landing on the apply clock survives into the next frame.
                r_up_req <= i_speed_up;
                r_dn_req <= i_speed_down;
            end else begin
                r_up_req <= r_up_req | i_speed_up;
                r_dn_req <= r_dn_req | i_speed_down;
            end
        end
    end

`ifdef LINEA_SCROLL_LAPS_EN
    logic [15:0] r_laps;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_laps <= 16'd0;
        end else if (w_apply && w_wrap) begin
            r_laps <= r_laps + 16'd1;
        end
    end
    assign o_laps = r_laps;
`endif

    assign o_posx       = LANE_X;
    assign o_posy       = r_pos[PW-1:FRAC];
    assign o_speed      = r_speed;
    assign o_moving     = (r_state != S_IDLE);
    assign o_frame_tick = w_apply;
endmodule

// File: tb/tb_linea_scroll_ctrl.sv
// tb/tb_linea_scroll_ctrl.sv - self-checking bench for linea_scroll_ctrl (table vectors + scoreboard model).
module tb_linea_scroll_ctrl;
    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [9:0] i_hcount = 10'd5, i_vcount = 10'd0;
    logic       i_run = 1'b0, i_speed_up = 1'b0, i_speed_down = 1'b0;
    logic [9:0] o_posx, o_posy;
    logic [3:0] o_speed;
    logic       o_moving, o_frame_tick;
`ifdef LINEA_SCROLL_LAPS_EN
    logic [15:0] o_laps;
`endif

    linea_scroll_ctrl dut (
        .i_clock(clk), .i_reset(i_reset), .i_hcount(i_hcount), .i_vcount(i_vcount),
        .i_run(i_run), .i_speed_up(i_speed_up), .i_speed_down(i_speed_down),
        .o_posx(o_posx), .o_posy(o_posy), .o_speed(o_speed), .o_moving(o_moving),
        .o_frame_tick(o_frame_tick)
`ifdef LINEA_SCROLL_LAPS_EN
        , .o_laps(o_laps)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { bit run; bit up; bit dn; int speed; int moving; int posy; } vec_t;
    typedef struct { int speed; int moving; int posy; int laps; } exp_t;

    vec_t tbl[17];
    exp_t sbq[$];
    int   n_cmp = 0, n_fail = 0;

    int   m_state, m_speed, m_pos, m_laps;
    bit   m_up, m_dn;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_speed = 0; m_pos = 0; m_laps = 0; m_up = 0; m_dn = 0;
    endtask

    task automatic do_reset(input bit pending_up);
        @(negedge clk);
        if (pending_up) begin
            i_speed_up = 1'b1;
            @(negedge clk);
            i_speed_up = 1'b0;
        end
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        model_reset();
        check("rst_posx", int'(o_posx), 305);
        check("rst_posy", int'(o_posy), 0);
        check("rst_speed", int'(o_speed), 0);
        check("rst_moving", int'(o_moving), 0);
        check("rst_tick", int'(o_frame_tick), 0);
`ifdef LINEA_SCROLL_LAPS_EN
        check("rst_laps", int'(o_laps), 0);
`endif
    endtask

    // Reference behaviour at the frame update point; pending presses were latched during the frame.
    task automatic model_apply(input bit run, input bit late_up);
        exp_t e;
        bit up, dn;
        up = m_up; dn = m_dn;
        m_up = late_up; m_dn = 0;
        m_pos = m_pos + m_speed;
        if (m_pos / 4 >= 480) begin
            m_pos = m_pos - 480 * 4;
            m_laps = (m_laps + 1) % 65536;
        end
        case (m_state)
            0: if (run) begin m_state = 1; m_speed = 1; end
            1: if (!run) begin
                   m_state = 2; m_speed = m_speed - 1;
               end else if (up && !dn) m_speed = (m_speed < 12) ? m_speed + 1 : 12;
               else if (dn && !up) m_speed = (m_speed > 1) ? m_speed - 1 : 1;
            default: if (run) begin
                   m_state = 1; if (m_speed == 0) m_speed = 1;
               end else begin
                   m_speed = (m_speed > 0) ? m_speed - 1 : 0;
                   if (m_speed == 0) m_state = 0;
               end
        endcase
        e.speed = m_speed; e.moving = (m_state != 0); e.posy = m_pos / 4; e.laps = m_laps;
        sbq.push_back(e);
    endtask

    task automatic frame(input bit run, input bit up, input bit dn, input bit late_up,
                         input int hold, input bit use_model, input vec_t tv);
        exp_t e;
        int ticks;
        @(negedge clk);
        i_run = run; i_vcount = 10'd100; i_hcount = 10'd5;
        @(negedge clk);
        i_speed_up = up; i_speed_down = dn;
        @(negedge clk);
        i_speed_up = 1'b0; i_speed_down = 1'b0;
        if (use_model) begin
            m_up = m_up | up; m_dn = m_dn | dn;
            model_apply(run, late_up);
        end else begin
            e.speed = tv.speed; e.moving = tv.moving; e.posy = tv.posy; e.laps = 0;
            sbq.push_back(e);
        end
        i_vcount = 10'd480; i_hcount = 10'd0;
        ticks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == hold - 1) i_hcount = 10'd1;
            if (o_frame_tick) begin
                ticks++;
                if (late_up) i_speed_up = 1'b1;
            end else begin
                i_speed_up = 1'b0;
            end
        end
        i_speed_up = 1'b0; i_vcount = 10'd0;
        check("tick_count", ticks, 1);
        if (sbq.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            check("posy", int'(o_posy), e.posy);
            check("speed", int'(o_speed), e.speed);
            check("moving", int'(o_moving), e.moving);
            check("posx", int'(o_posx), 305);
`ifdef LINEA_SCROLL_LAPS_EN
            check("laps", int'(o_laps), e.laps);
`endif
        end
    endtask

    vec_t nv;

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 1, 0};
        tbl[4]  = '{1, 0, 0, 1, 1, 0};
        tbl[5]  = '{1, 0, 0, 1, 1, 0};
        tbl[6]  = '{1, 0, 0, 1, 1, 0};
        tbl[7]  = '{1, 0, 0, 1, 1, 1};
        tbl[8]  = '{1, 1, 1, 1, 1, 1};
        tbl[9]  = '{1, 0, 1, 1, 1, 1};
        tbl[10] = '{1, 1, 0, 2, 1, 1};
        tbl[11] = '{1, 1, 0, 3, 1, 2};
        tbl[12] = '{1, 0, 0, 3, 1, 3};
        tbl[13] = '{0, 0, 0, 2, 1, 3};
        tbl[14] = '{0, 1, 0, 1, 1, 4};
        tbl[15] = '{0, 0, 0, 0, 0, 4};
        tbl[16] = '{0, 0, 0, 0, 0, 4};
        nv = '{0, 0, 0, 0, 0, 0};

        do_reset(1'b0);
        for (int i = 0; i < 17; i++)
            frame(tbl[i].run, tbl[i].up, tbl[i].dn, 1'b0, (i % 3) + 1, 1'b0, tbl[i]);

        // Press pending at reset must be discarded; a press on the apply clock carries over.
        do_reset(1'b1);
        frame(1, 0, 0, 0, 1, 1, nv);
        frame(1, 0, 0, 0, 2, 1, nv);
        frame(1, 0, 0, 1, 1, 1, nv);
        frame(1, 0, 0, 0, 1, 1, nv);

        for (int i = 0; i < 20; i++) frame(1, 1, 0, 0, 1, 1, nv);
        for (int i = 0; i < 170; i++) frame(1, 0, 0, 0, 1, 1, nv);

        for (int i = 0; i < 9; i++) frame(1, 0, 1, 0, 1, 1, nv);
        for (int i = 0; i < 4; i++) frame(0, 1, 0, 0, 2, 1, nv);
        for (int i = 0; i < 2; i++) frame(0, 0, 0, 0, 1, 1, nv);
        frame(1, 0, 0, 0, 1, 1, nv);
        frame(1, 1, 0, 0, 1, 1, nv);
        frame(0, 0, 0, 0, 1, 1, nv);
        frame(0, 0, 0, 0, 1, 1, nv);
        frame(1, 0, 0, 0, 1, 1, nv);
        frame(0, 0, 0, 0, 1, 1, nv);
        frame(0, 0, 0, 0, 1, 1, nv);
        do_reset(1'b0);

        for (int i = 0; i < 40; i++)
            frame(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 1),
                  $urandom_range(1, 3), 1, nv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
